// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - access-size encodings and memory-stage FSM states
package cpu_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/cpu_memory_align.sv
// rtl/cpu_memory_align.sv - big-endian byte-lane steering, store replication, load zero-extension
module cpu_memory_align
  import cpu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  output logic [3:0]  sel,
  output logic [31:0] store_lanes,
  output logic        aligned,
  input  logic [1:0]  load_size,
  input  logic [1:0]  load_offset,
  input  logic [31:0] load_data,
  output logic [31:0] load_value
);

  logic [31:0] byte_shifted;

  always_comb begin
    sel         = 4'b1111;
    store_lanes = store_data;
    aligned     = (offset == 2'b00);
    case (size)
      SIZE_BYTE: begin
        sel         = 4'b1000 >> offset;
        store_lanes = {4{store_data[7:0]}};
        aligned     = 1'b1;
      end
      SIZE_HALF: begin
        sel         = offset[1] ? 4'b0011 : 4'b1100;
        store_lanes = {2{store_data[15:0]}};
        aligned     = ~offset[0];
      end
      default: ;
    endcase
  end

  // offset 0 sits in the top byte, so shift down by (3 - offset) bytes
  assign byte_shifted = load_data >> {~load_offset, 3'b000};

  always_comb begin
    load_value = load_data;
    case (load_size)
      SIZE_BYTE: load_value = {24'h0, byte_shifted[7:0]};
      SIZE_HALF: load_value = {16'h0, load_offset[1] ? load_data[15:0] : load_data[31:16]};
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_memory.sv
// rtl/cpu_memory.sv - memory stage with Wishbone-classic master; optional bus timeout via CPU_MEMORY_TIMEOUT_EN
module cpu_memory
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        op_ld_i,
  input  logic        op_st_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] result_i,
  input  logic [31:0] store_data_i,
  input  logic        register_write_enable_i,
  input  logic [3:0]  register_write_index_i,
  output logic        register_write_enable_o,
  output logic [3:0]  register_write_index_o,
  output logic [31:0] value_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_error_o
);

  state_t      state, state_n;
  logic        mem_op, aligned, timeout_hit;
  logic [3:0]  sel_w;
  logic [31:0] wdata_w, load_value;
  logic [1:0]  size_q, off_q;
  logic        is_ld_q;
  logic [3:0]  idx_q;

  assign mem_op = op_ld_i | op_st_i;

  cpu_memory_align u_align (
    .size        (size_i),
    .offset      (result_i[1:0]),
    .store_data  (store_data_i),
    .sel         (sel_w),
    .store_lanes (wdata_w),
    .aligned     (aligned),
    .load_size   (size_q),
    .load_offset (off_q),
    .load_data   (dat_i),
    .load_value  (load_value)
  );

`ifdef CPU_MEMORY_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] bus_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i || state != ST_BUS) bus_cnt <= '0;
    else                           bus_cnt <= bus_cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_BUS) && !ack_i && (bus_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  // parameter stays in the interface; this compare folds to constant 0
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    stall_o = 1'b0;
    case (state)
      ST_IDLE: if (mem_op && aligned) begin
        state_n = ST_BUS;
        stall_o = 1'b1;
      end
      ST_BUS: begin
        if (ack_i)            state_n = ST_RESP;
        else if (timeout_hit) state_n = ST_IDLE;
        else                  stall_o = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      register_write_enable_o <= 1'b0;
      register_write_index_o  <= '0;
      value_o     <= '0;
      adr_o       <= '0;
      dat_o       <= '0;
      sel_o       <= '0;
      we_o        <= 1'b0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      misalign_o  <= 1'b0;
      bus_error_o <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      is_ld_q     <= 1'b0;
      idx_q       <= '0;
    end else begin
      register_write_enable_o <= 1'b0;
      misalign_o  <= 1'b0;
      bus_error_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_op && aligned) begin
            cyc_o   <= 1'b1;
            stb_o   <= 1'b1;
            we_o    <= op_st_i;
            adr_o   <= {result_i[31:2], 2'b00};
            sel_o   <= sel_w;
            dat_o   <= wdata_w;
            size_q  <= size_i;
            off_q   <= result_i[1:0];
            is_ld_q <= ~op_st_i;
            idx_q   <= register_write_index_i;
          end else if (mem_op) begin
            misalign_o <= 1'b1;
          end else begin
            register_write_enable_o <= register_write_enable_i;
            register_write_index_o  <= register_write_index_i;
            value_o                 <= result_i;
          end
        end
        ST_BUS: begin
          if (ack_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            register_write_enable_o <= is_ld_q;
            if (is_ld_q) begin
              register_write_index_o <= idx_q;
              value_o                <= load_value;
            end
          end else if (timeout_hit) begin
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            bus_error_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
